// File: rtl/add_round_key_stage_if.sv
// ============================================================================
// Module      : add_round_key_stage_if
// Description : Stream bundle for the AES AddRoundKey stage: input beat
//               (state, key, last) and output beat (state, round, last, err).
//               With ADD_ROUND_KEY_PARITY_EN defined, out_parity is added.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add_round_key_stage_if #(
    parameter int RW = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0][3:0][7:0]   in_state;
    logic [3:0][3:0][7:0]   in_key;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0][3:0][7:0]   out_state;
    logic [RW-1:0]          out_round;
    logic                   out_last;
    logic                   err;
`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [3:0][3:0]        out_parity;
`endif

    // Stage side: consumes the input beat, produces the output beat.
    modport slave (
        input  in_valid, in_state, in_key, in_last, out_ready,
        output in_ready, out_valid, out_state, out_round, out_last, err
`ifdef ADD_ROUND_KEY_PARITY_EN
        , output out_parity
`endif
    );

    // Environment side: produces the input beat, consumes the output beat.
    modport master (
        output in_valid, in_state, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_state, out_round, out_last, err
`ifdef ADD_ROUND_KEY_PARITY_EN
        , input out_parity
`endif
    );
endinterface

`default_nettype wire

// File: rtl/add_round_key_stage.sv
// ============================================================================
// Module      : add_round_key_stage
// Description : Registered AES AddRoundKey stage. XORs the MixColumns state
//               with the round key, tags each beat with its round index and
//               forwards it through a 2-entry skid buffer (output register +
//               skid register) so in_ready depends on registered state only.
//               Optional: ADD_ROUND_KEY_PARITY_EN adds a per-byte even-parity
//               output stored alongside each beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    add_round_key_stage_if.slave    bus
);
    localparam logic [RW-1:0] c_NR = RW'(NR);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [3:0][3:0][7:0]   r_out_state;
    logic [RW-1:0]          r_out_round;
    logic                   r_out_last;
    logic [3:0][3:0][7:0]   r_skid_state;
    logic [RW-1:0]          r_skid_round;
    logic                   r_skid_last;
    logic [RW-1:0]          r_cnt;
    logic                   r_err;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_accept;
    logic                   w_drain;
    logic                   w_load_out;
    logic                   w_load_skid;
    logic                   w_out_from_skid;
    logic [3:0][3:0][7:0]   w_cap_state;

    // Storage occupancy alone decides the handshake outputs.
    assign w_in_ready  = (r_state != S_TWO);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_drain     = w_out_valid & bus.out_ready;

    // AddRoundKey is a bytewise XOR; on packed arrays it is one wide XOR.
    assign w_cap_state = bus.in_state ^ bus.in_key;

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Next occupancy and register load selects.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_out  = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_drain) begin
                    w_load_out      = 1'b1;
                    w_out_from_skid = 1'b1;
                    w_state_nxt     = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Output and skid payload registers; the output register only changes on
    // a load, which keeps the beat stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_state  <= '0;
            r_out_round  <= '0;
            r_out_last   <= 1'b0;
            r_skid_state <= '0;
            r_skid_round <= '0;
            r_skid_last  <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out_state <= w_out_from_skid ? r_skid_state : w_cap_state;
                r_out_round <= w_out_from_skid ? r_skid_round : r_cnt;
                r_out_last  <= w_out_from_skid ? r_skid_last  : bus.in_last;
            end
            if (w_load_skid) begin
                r_skid_state <= w_cap_state;
                r_skid_round <= r_cnt;
                r_skid_last  <= bus.in_last;
            end
        end
    end

    // Round counter: restarts after a last beat, wraps with a sticky error
    // when a block runs past round NR without being closed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_last) begin
                r_cnt <= '0;
            end else if (r_cnt == c_NR) begin
                r_cnt <= '0;
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_state = r_out_state;
    assign bus.out_round = r_out_round;
    assign bus.out_last  = r_out_last;
    assign bus.err       = r_err;

`ifdef ADD_ROUND_KEY_PARITY_EN
    logic [3:0][3:0]        w_cap_par;
    logic [3:0][3:0]        r_out_par;
    logic [3:0][3:0]        r_skid_par;

    for (genvar gr = 0; gr < 4; gr++) begin : g_par_row
        for (genvar gc = 0; gc < 4; gc++) begin : g_par_col
            assign w_cap_par[gr][gc] = ^w_cap_state[gr][gc];
        end
    end

    // Parity travels with its beat through the same two registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_par  <= '0;
            r_skid_par <= '0;
        end else begin
            if (w_load_out)  r_out_par  <= w_out_from_skid ? r_skid_par : w_cap_par;
            if (w_load_skid) r_skid_par <= w_cap_par;
        end
    end

    assign bus.out_parity = r_out_par;
`endif

endmodule

`default_nettype wire

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AES AddRoundKey stage directly downstream of mixed_column_block.
- XORs the 4x4 state produced by MixColumns with the round key and forwards the result over a valid/ready handshake.
- Tracks the round index of each block and flags the final round to the round controller.
- Contains a 2-entry skid buffer so in_ready does not depend combinationally on out_ready.

Parameters:
- NR, 10, number of cipher rounds per block (10/12/14). Legal round indices are 0..NR.
- RW, 4, width of the round index field. Must satisfy 2^RW > NR.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_state, in_key and in_last are valid.
- in_ready  output  1  stage can accept a beat; transfer happens when in_valid and in_ready are both high.
- in_state  input  [3:0][3:0][7:0]  state from mixed_column_block, indexed [row][col].
- in_key  input  [3:0][3:0][7:0]  round key, same [row][col] indexing.
- in_last  input  1  this beat is the final round of the block.
- out_valid  output  1  output beat is valid.
- out_ready  input  1  downstream accepts the beat.
- out_state  output  [3:0][3:0][7:0]  in_state ^ in_key, bytewise.
- out_round  output  RW  round index of this beat.
- out_last  output  1  copy of in_last for this beat.
- err  output  1  sticky round-overflow flag.

Behaviour:
- Reset, asynchronous: out_valid=0, out_state=0, out_round=0, out_last=0, err=0, round counter=0, skid buffer empty, in_ready=1 on the first cycle after rst deasserts.
- Reset asserted mid-operation discards all buffered beats immediately.
- Datapath: out_state[r][c] = in_state[r][c] ^ in_key[r][c] for every r, c. Pure XOR, no carries, computed at capture.
- Latency: 1 cycle from an accepted input to out_valid when the output register is empty or draining.
- Storage states: EMPTY (0 beats), ONE (output register full), TWO (output register and skid register full).
- in_ready = 1 in EMPTY and ONE; in_ready = 0 in TWO. in_ready is a function of registered state only.
- EMPTY + accept -> ONE.
- ONE + accept without drain -> TWO (beat goes to skid).
- ONE + accept with drain -> ONE (output register reloads).
- ONE + drain only -> EMPTY.
- TWO + drain -> ONE (skid moves to output register).
- Order is strictly FIFO. No beat is dropped or duplicated.
- Output hold rule: while out_valid=1 and out_ready=0, out_state, out_round and out_last stay stable.
- Round counter:
  - Each accepted beat is tagged with the current counter value.
  - Counter increments after each accepted beat.
  - Accepting a beat with in_last=1 resets the counter to 0 for the next block.
  - If a beat is accepted with counter==NR and in_last=0, that beat is tagged NR, err sets, and the counter wraps to 0.
  - err clears only on rst.
- Simultaneous accept and drain in the same cycle are both honoured in that cycle.

Optional Feature:
- Macro: ADD_ROUND_KEY_PARITY_EN.
- Defined:
  - Adds output port out_parity [3:0][3:0] with out_parity[r][c] = ^out_state[r][c] (even-parity bit per byte).
  - Parity is computed at capture, stored alongside the beat in both registers, and reset to 0.
- Undefined: port absent; no parity logic or storage.

Test Plan:
- FIPS-197 round 1 vector: in_state columns 046681E5 E0CB199A 48F8D37A 2806264C, in_key A0FAFE17 88542CB1 23A33939 2A6C7605, out_ready=1 -> one cycle later out_state columns A49C7FF2 689F352B 6B5BEA43 026A5049, out_round=0.
- Backpressure: out_ready=0, three back-to-back in_valid beats -> first two accepted, in_ready low on the third; raise out_ready -> beats emerge in order and the third is then accepted; no loss or duplication.
- Full block: NR=10, send 11 beats with in_last on the 11th -> out_round sequence 0..10, out_last=1 only on round 10; next block starts at round 0; err=0.
- Overflow: send 12 beats with in_last=0 -> the 11th beat carries out_round=10 and err sets; the 12th beat carries out_round=0; err stays 1 until rst.
- Mid-operation reset: assert rst while in state TWO -> out_valid=0, err=0, counter=0 immediately; after release, the first beat gets out_round=0.
- ADD_ROUND_KEY_PARITY_EN defined: in_state all 0x00, in_key all 0x01 -> out_state all 0x01, every out_parity bit = 1.
